// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between two requesters, one consumer and the arbiter.
// master: requester/consumer side (drives requests and rsp_ready).
// slave : arbiter side (drives reqN_ready and the response payload).
interface logic_unit_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin arbiter in front of a bitwise logic unit.
// Ports:
//   clk      - rising-edge clock
//   rst      - synchronous active-high reset
//   bus      - slave side of logic_unit_arbiter_if (requests in, response out)
//   busy     - high whenever the FSM is not idle
//   ops_done - wrapping count of completed responses
module logic_unit_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  logic_unit_arbiter_if.slave   bus,
  output logic                  busy,
  output logic [7:0]            ops_done
);

  localparam int unsigned OP_W  = 3;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_ptr;
  logic [OP_W-1:0]  r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_id;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_id;
  logic             r_rsp_err;
  logic [CNT_W-1:0] r_ops_done;

  logic             w_any_req;
  logic             w_grant_id;
  logic             w_grant;
  logic             w_req0_ready;
  logic             w_req1_ready;
  logic             w_rsp_valid;
  logic             w_rsp_fire;
  logic             w_busy;
  logic [WIDTH-1:0] w_result;
  logic             w_result_err;

  // Round-robin pick: preferred requester wins if valid, otherwise the other one.
  always_comb begin
    w_any_req  = bus.req0_valid | bus.req1_valid;
    w_grant_id = r_ptr;
    if (r_ptr) w_grant_id = bus.req1_valid ? 1'b1 : 1'b0;
    else       w_grant_id = bus.req0_valid ? 1'b0 : 1'b1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any_req) w_state_nxt = ST_EXEC;
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: if (bus.rsp_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs; grants are suppressed while reset is asserted.
  always_comb begin
    w_grant      = 1'b0;
    w_req0_ready = 1'b0;
    w_req1_ready = 1'b0;
    w_rsp_valid  = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_grant      = w_any_req & ~rst;
        w_req0_ready = w_grant & ~w_grant_id;
        w_req1_ready = w_grant &  w_grant_id;
      end
      ST_EXEC: w_busy = 1'b1;
      ST_RESP: begin
        w_busy      = 1'b1;
        w_rsp_valid = 1'b1;
      end
      default: w_busy = 1'b0;
    endcase
  end

  assign w_rsp_fire = w_rsp_valid & bus.rsp_ready;

  // Bitwise logic unit on the captured operands; opcode 7 is reserved.
  always_comb begin
    w_result_err = 1'b0;
    case (r_op)
      3'd0:    w_result = r_a & r_b;
      3'd1:    w_result = r_a | r_b;
      3'd2:    w_result = ~r_a;
      3'd3:    w_result = ~(r_a & r_b);
      3'd4:    w_result = ~(r_a | r_b);
      3'd5:    w_result = r_a ^ r_b;
      3'd6:    w_result = ~(r_a ^ r_b);
      default: begin
        w_result     = '0;
        w_result_err = 1'b1;
      end
    endcase
  end

  // Operand capture, response registers, pointer and completion counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= 1'b0;
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_id       <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_id   <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_ops_done <= '0;
    end else begin
      if (w_grant) begin
        r_ptr <= ~w_grant_id;
        r_id  <= w_grant_id;
        r_op  <= w_grant_id ? bus.req1_op : bus.req0_op;
        r_a   <= w_grant_id ? bus.req1_a  : bus.req0_a;
        r_b   <= w_grant_id ? bus.req1_b  : bus.req0_b;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_data <= w_result;
        r_rsp_err  <= w_result_err;
        r_rsp_id   <= r_id;
      end
      if (w_rsp_fire) r_ops_done <= r_ops_done + CNT_W'(1);
    end
  end

  assign bus.req0_ready = w_req0_ready;
  assign bus.req1_ready = w_req1_ready;
  assign bus.rsp_valid  = w_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_err    = r_rsp_err;
  assign busy           = w_busy;
  assign ops_done       = r_ops_done;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter: directed scenarios plus random traffic
// against a truth-table / last-granted reference model.
module tb_logic_unit_arbiter;

  localparam int unsigned WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [7:0] ops_done;

  always #5 clk = ~clk;

  logic_unit_arbiter_if #(.WIDTH(WIDTH)) bus ();

  logic_unit_arbiter #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .ops_done (ops_done)
  );

  int         checks = 0;
  int         errors = 0;
  logic       last_grant;   // model: requester granted most recently (1 after reset => prefer 0)
  logic [7:0] exp_ops;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Per-bit truth table lookup, index {a_bit, b_bit}.
  function automatic logic [7:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [3:0] tt;
    logic [7:0] r;
    case (op)
      3'd0:    tt = 4'b1000;
      3'd1:    tt = 4'b1110;
      3'd2:    tt = 4'b0011;
      3'd3:    tt = 4'b0111;
      3'd4:    tt = 4'b0001;
      3'd5:    tt = 4'b0110;
      3'd6:    tt = 4'b1001;
      default: tt = 4'b0000;
    endcase
    for (int i = 0; i < 8; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  task automatic scramble_inputs();
    bus.req0_op = 3'($urandom);
    bus.req0_a  = 8'($urandom);
    bus.req0_b  = 8'($urandom);
    bus.req1_op = 3'($urandom);
    bus.req1_a  = 8'($urandom);
    bus.req1_b  = 8'($urandom);
  endtask

  // Full transaction with rsp_ready high; starts and ends at posedge+1 of an IDLE cycle.
  task automatic txn(input logic v0, input logic v1,
                     input logic [2:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                     input logic [2:0] op1, input logic [7:0] a1, input logic [7:0] b1);
    logic       g;
    logic [2:0] gop;
    logic [7:0] er;
    if (v0 && v1) g = ~last_grant;
    else          g = v1;
    gop = g ? op1 : op0;
    er  = g ? ref_op(op1, a1, b1) : ref_op(op0, a0, b0);
    bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
    bus.rsp_ready  = 1'b1;
    #1;
    check("req0_ready_grant", 32'(bus.req0_ready), g ? 32'd0 : 32'd1);
    check("req1_ready_grant", 32'(bus.req1_ready), g ? 32'd1 : 32'd0);
    last_grant = g;
    @(posedge clk); #1;
    scramble_inputs();
    #1;
    check("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("exec_busy", 32'(busy), 32'd1);
    check("exec_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    @(posedge clk); #1;
    check("resp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("resp_data", 32'(bus.rsp_data), 32'(er));
    check("resp_id", 32'(bus.rsp_id), 32'(g));
    check("resp_err", 32'(bus.rsp_err), (gop == 3'd7) ? 32'd1 : 32'd0);
    check("resp_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    @(posedge clk); #1;
    exp_ops = exp_ops + 8'd1;
    check("done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
    check("ops_done", 32'(ops_done), 32'(exp_ops));
    check("idle_data_hold", 32'(bus.rsp_data), 32'(er));
  endtask

  task automatic clear_valids();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] v;
    rst = 1'b1;
    clear_valids();
    scramble_inputs();
    bus.rsp_ready = 1'b1;
    last_grant = 1'b1;
    exp_ops = 8'd0;

    // Reset state and ready suppression during reset.
    repeat (2) @(posedge clk);
    #1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    check("rst_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_ops_done", 32'(ops_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    clear_valids();
    rst = 1'b0;

    // Basic AND from requester 0.
    txn(1'b1, 1'b0, 3'd0, 8'hF0, 8'h3C, 3'd0, 8'h00, 8'h00);

    // Every opcode including the reserved one.
    for (int op = 0; op < 8; op++) txn(1'b1, 1'b0, 3'(op), 8'hA5, 8'h0F, 3'd0, 8'h00, 8'h00);
    clear_valids();

    // Both requesters valid from reset: grants alternate starting with 0.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    last_grant = 1'b1;
    exp_ops = 8'd0;
    check("rst2_ops_done", 32'(ops_done), 32'd0);
    for (int i = 0; i < 4; i++)
      txn(1'b1, 1'b1, 3'(i), 8'(8'h11 * (i + 1)), 8'h5A, 3'(i + 3), 8'h96, 8'(8'h22 * (i + 1)));
    clear_valids();

    // Backpressure: response held for 5 cycles while requester 1 churns.
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = 3'd5; bus.req0_a = 8'h3C; bus.req0_b = 8'hFF;
    #1;
    check("bp_grant0", 32'(bus.req0_ready), 32'd1);
    last_grant = 1'b0;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    scramble_inputs();
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      bus.req1_valid = 1'b1;
      bus.req1_a = 8'($urandom);
      bus.req1_b = 8'($urandom);
      bus.req1_op = 3'($urandom);
      #1;
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_rsp_data", 32'(bus.rsp_data), 32'hC3);
      check("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_still_valid", 32'(bus.rsp_valid), 32'd1);
    @(posedge clk); #1;
    clear_valids();
    exp_ops = exp_ops + 8'd1;
    check("bp_done_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_ops_done", 32'(ops_done), 32'(exp_ops));

    // Reset during EXEC drops the operation and returns the pointer to 0.
    bus.req1_valid = 1'b1; bus.req1_op = 3'd1; bus.req1_a = 8'h0F; bus.req1_b = 8'hF0;
    #1;
    check("abort_grant1", 32'(bus.req1_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.req0_valid = 1'b1;
    #1;
    check("abort_rst_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_valids();
    last_grant = 1'b1;
    exp_ops = 8'd0;
    #1;
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ops_done", 32'(ops_done), 32'd0);
    @(posedge clk); #1;
    check("abort_no_late_rsp", 32'(bus.rsp_valid), 32'd0);
    txn(1'b1, 1'b1, 3'd6, 8'hC3, 8'h5A, 3'd2, 8'h77, 8'h00);

    // Random traffic until the completion counter wraps.
    for (int i = 0; i < 255; i++) begin
      v = 2'($urandom_range(1, 3));
      txn(v[0], v[1], 3'($urandom), 8'($urandom), 8'($urandom),
          3'($urandom), 8'($urandom), 8'($urandom));
    end
    clear_valids();
    check("ops_done_wrap", 32'(ops_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_op  input  3  requester 0 opcode.
REQ-007 req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-008 req1_valid, req1_ready, req1_op, req1_a, req1_b: same as REQ-004..007, for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_id  output  1  index of the requester that owns the result.
REQ-012 rsp_data  output  WIDTH  result.
REQ-013 rsp_err  output  1  opcode was reserved.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 ops_done  output  8  count of completed responses.

Function
REQ-016 Opcode map SHALL be bitwise over WIDTH: 0 AND, 1 OR, 2 NOT a (b ignored), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved.
REQ-017 Opcode 7 SHALL produce rsp_data = 0 and rsp_err = 1; all other opcodes SHALL produce rsp_err = 0.
REQ-018 FSM states SHALL be IDLE, EXEC and RESP; only IDLE accepts requests.
REQ-019 IDLE: if any reqN_valid is high, the arbiter SHALL grant exactly one requester, assert its reqN_ready combinationally in that cycle, capture op/a/b/id, and go to EXEC.
REQ-020 Arbitration SHALL be round-robin: a 1-bit priority pointer selects the preferred requester; the other requester is granted only if the preferred one is not valid.
REQ-021 After each grant, the pointer SHALL point to the requester that was not granted.
REQ-022 reqN_ready SHALL be 0 in EXEC and RESP, and 0 for the non-granted requester.
REQ-023 EXEC: the result SHALL be computed from the captured operands, registered into rsp_data/rsp_err/rsp_id, and the FSM SHALL go to RESP; EXEC lasts exactly 1 cycle.
REQ-024 RESP: rsp_valid SHALL be 1; rsp_data, rsp_id and rsp_err SHALL be held stable until rsp_valid && rsp_ready.
REQ-025 On rsp_valid && rsp_ready: rsp_valid SHALL go to 0 on the next edge, the FSM SHALL go to IDLE, and ops_done SHALL increment by 1, wrapping from 255 to 0.
REQ-026 Latency: for a request accepted in cycle N, rsp_valid SHALL rise in cycle N+2. With rsp_ready held high, minimum issue interval is 3 cycles.
REQ-027 Changes on request inputs after acceptance SHALL NOT affect the in-flight result.
REQ-028 If rsp_ready is already high when RESP is entered, the response SHALL complete in that first RESP cycle.
REQ-029 rsp_data, rsp_id and rsp_err SHALL retain their last values while in IDLE.

Reset
REQ-030 While rst is high at a clock edge, the block SHALL set: state IDLE, rsp_valid 0, rsp_data 0, rsp_id 0, rsp_err 0, pointer to requester 0, ops_done 0.
REQ-031 reqN_ready SHALL be 0 during any cycle in which rst is high.
REQ-032 A reset asserted in EXEC or RESP SHALL drop the in-flight operation; no response is produced and ops_done is not incremented.

Verification
REQ-033 Scenario: reset, then req0 AND with a=8'hF0, b=8'h3C, rsp_ready=1 -> req0_ready in cycle N; rsp_valid in N+2 with rsp_data=8'h30, rsp_id=0, rsp_err=0; ops_done=1.
REQ-034 Scenario: ops 0..6 with a=8'hA5, b=8'h0F -> results 8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55; op 7 -> rsp_data 8'h00, rsp_err=1.
REQ-035 Scenario: both requesters continuously valid from reset, rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id follows the same sequence.
REQ-036 Scenario: rsp_ready held 0 for 5 cycles in RESP, with req1 toggling operands -> rsp_valid and rsp_data stable for all 5 cycles, req1_ready stays 0; completion occurs 1 cycle after rsp_ready goes high.
REQ-037 Scenario: rst pulsed in EXEC -> next cycle rsp_valid=0, busy=0, ops_done unchanged (0), pointer at requester 0.
REQ-038 Scenario: 256 completed operations -> ops_done wraps to 0.
